// File: rtl/delta_event_sink.sv
// delta_event_sink: receive end of the send-on-delta channel protocol.
// Holds the last reported value of 4 channels, re-emits every accepted
// event through a small FIFO, and flags channels that have gone silent.
module delta_event_sink #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALE_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,     // synchronous, active-high despite the name
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_ch,
  input  logic [7:0] ev_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_ch,
  output logic [7:0] out_data,
  input  logic [1:0] rd_ch,
  output logic [7:0] rd_data,
  output logic [3:0] stale,
  output logic [7:0] evt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   AGE_MAX  = 16'(STALE_CYCLES);

  logic [7:0]    val_q [4];
  logic [7:0]    val_d [4];
  logic [15:0]   age_q [4];
  logic [15:0]   age_d [4];
  logic [3:0]    vld_q, vld_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    evt_cnt_q, evt_cnt_d;
  logic          accept;
  logic          pop;

  assign ev_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign accept    = ev_valid & ev_ready;
  assign pop       = out_valid & out_ready;
  assign out_ch    = mem_q[rd_ptr_q][9:8];
  assign out_data  = mem_q[rd_ptr_q][7:0];
  assign rd_data   = val_q[rd_ch];
  assign evt_cnt   = evt_cnt_q;

  // Stale flags derived purely from registered validity and age.
  always_comb begin
    stale = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      stale[i] = !vld_q[i] || (age_q[i] == AGE_MAX);
    end
  end

  // Next-state: channel table, age timers, FIFO pointers/count, event counter.
  always_comb begin
    val_d     = val_q;
    age_d     = age_q;
    vld_d     = vld_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    evt_cnt_d = evt_cnt_q;

    for (int unsigned i = 0; i < 4; i++) begin
      if (accept && (ev_ch == 2'(i))) begin
        val_d[i] = ev_data;
        vld_d[i] = 1'b1;
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 16'd1;
      end
    end

    if (accept) begin
      mem_d[wr_ptr_q] = {ev_ch, ev_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      evt_cnt_d       = evt_cnt_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset clears everything including FIFO storage.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        val_q[i] <= '0;
        age_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      evt_cnt_q <= '0;
    end else begin
      val_q     <= val_d;
      age_q     <= age_d;
      vld_q     <= vld_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

endmodule

// File: tb/tb_delta_event_sink.sv
// Directed bench for delta_event_sink (DEPTH=4, STALE_CYCLES=8).
module tb_delta_event_sink;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [7:0] ev_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic [1:0] rd_ch;
  logic [7:0] rd_data;
  logic [3:0] stale;
  logic [7:0] evt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  delta_event_sink #(.DEPTH(4), .STALE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_data(ev_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .stale(stale), .evt_cnt(evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one event and hold it until ready is seen before an edge.
  task automatic send(input logic [1:0] ch, input logic [7:0] data);
    bit done = 0;
    ev_valid = 1'b1;
    ev_ch    = ch;
    ev_data  = data;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ev_ready) done = 1;
      step();
    end
    ev_valid = 1'b0;
    if (done) exp_cnt = (exp_cnt + 1) % 256;
    else check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    step();
    rst_n   = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q[$];
    logic [7:0] exp_drain [4];
    rst_n = 1'b1; ev_valid = 1'b0; ev_ch = '0; ev_data = '0;
    out_ready = 1'b0; rd_ch = '0;
    step();
    do_reset();

    // Reset state
    #1;
    check("rst_ev_ready", ev_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_stale", stale, 4'hF);
    check("rst_evt_cnt", evt_cnt, 0);

    // 1) single event on ch2
    send(2'd2, 8'h5A);
    rd_ch = 2'd2; #1;
    check("t1_rd_data", rd_data, 8'h5A);
    check("t1_stale", stale, 4'b1011);
    check("t1_evt_cnt", evt_cnt, 1);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_ch", out_ch, 2);
    check("t1_out_data", out_data, 8'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_popped", out_valid, 0);

    // 2) fill, hold the 5th, one pop, drain in order
    send(2'd0, 8'h11);
    send(2'd1, 8'h22);
    send(2'd2, 8'h33);
    send(2'd3, 8'h44);
    check("t2_full_ready", ev_ready, 0);
    ev_valid = 1'b1; ev_ch = 2'd1; ev_data = 8'h55;
    step();
    step();
    check("t2_held_ready", ev_ready, 0);
    check("t2_held_cnt", evt_cnt, 5);
    check("t2_head_stable", out_data, 8'h11);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_ready_after_pop", ev_ready, 1);
    check("t2_cnt_before", evt_cnt, 5);
    step();
    ev_valid = 1'b0;
    exp_cnt = 6;
    check("t2_fifth_accepted", evt_cnt, 6);
    exp_drain = '{8'h22, 8'h33, 8'h44, 8'h55};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_data", out_data, exp_drain[i]);
      step();
    end
    out_ready = 1'b0;
    check("t2_empty", out_valid, 0);

    // 3) two entries held, push+pop for 10 cycles
    send(2'd0, 8'hA0);
    send(2'd1, 8'hA1);
    q.push_back({2'd0, 8'hA0});
    q.push_back({2'd1, 8'hA1});
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ev_valid = 1'b1;
      ev_ch    = 2'(i % 4);
      ev_data  = 8'hB0 + 8'(i);
      check("t3_ready", ev_ready, 1);
      check("t3_head", {out_ch, out_data}, q[0]);
      step();
      void'(q.pop_front());
      q.push_back({2'(i % 4), 8'hB0 + 8'(i)});
      exp_cnt = (exp_cnt + 1) % 256;
    end
    ev_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t3_tail_valid", out_valid, 1);
      check("t3_tail", {out_ch, out_data}, q[0]);
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
    check("t3_count_two", out_valid, 0);
    check("t3_evt_cnt", evt_cnt, exp_cnt);

    // 4) stale timer on ch0 with STALE_CYCLES=8
    out_ready = 1'b1;
    send(2'd0, 8'h7E);
    for (int k = 1; k <= 9; k++) begin
      check("t4_stale0", stale[0], (k == 9) ? 1 : 0);
      if (k < 9) step();
    end
    send(2'd0, 8'h7F);
    check("t4_cleared", stale[0], 0);
    rd_ch = 2'd0; #1;
    check("t4_rd_data", rd_data, 8'h7F);

    // 5) counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) send(2'(i % 4), 8'(i));
    check("t5_cnt_255", evt_cnt, 255);
    send(2'd3, 8'hEE);
    check("t5_wrap_0", evt_cnt, 0);
    send(2'd3, 8'hEF);
    check("t5_wrap_1", evt_cnt, 1);
    step();
    out_ready = 1'b0;

    // 6) reset with queued entries and a pending event
    do_reset();
    send(2'd1, 8'h77);
    send(2'd2, 8'h78);
    send(2'd3, 8'h79);
    check("t6_queued", out_valid, 1);
    ev_valid = 1'b1; ev_ch = 2'd1; ev_data = 8'h99;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    rd_ch = 2'd1; #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_stale", stale, 4'hF);
    check("t6_rd_data", rd_data, 0);
    check("t6_evt_cnt", evt_cnt, 0);
    check("t6_ev_ready", ev_ready, 1);
    ev_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
